int_stim_gen: RTL and testbench
===============================

Name: int_stim_gen

Overview:
Multi-channel interrupt stimulus generator for the CPU test harness. It replaces the single hard-wired, one-shot interrupt with N independently programmable channels. Each channel fires when the macroscopic PC reaches a programmed address, can re-fire a programmed number of times, and is acknowledged by a store to the interrupt-acknowledge address. It sits between the CPU's macroscopic_pc / data-bus outputs and the CPU interrupt input.

Parameters:
NCH, 4, number of interrupt channels (1..32)
CNT_W, 4, width of per-channel fire counter
ACK_ADDR, 32'h0000_7F20, word address whose store acknowledges interrupts
TIMEOUT, 256, cycles a channel may stay pending before auto-drop (only with INT_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-low reset
macroscopic_pc  in  32  CPU macroscopic PC; bits [1:0] ignored
m_data_addr  in  32  CPU data-bus address
m_data_wdata  in  32  CPU store data; bit i acknowledges channel i
m_data_byteen  in  4  CPU store byte enables; nonzero = store
cfg_we  in  1  configuration write strobe
cfg_ch  in  $clog2(NCH) (min 1)  channel being configured
cfg_pc  in  32  trigger PC for cfg_ch; bits [1:0] ignored
cfg_cnt  in  CNT_W  fire count for cfg_ch; 0 disarms
interrupt  out  1  OR of int_vec, to CPU
int_vec  out  NCH  per-channel pending flags
fired_total  out  16  saturating count of assertions across all channels
timeout_flag  out  NCH  sticky per-channel timeout indicator

Behaviour:
- Reset (reset==0 at posedge): every channel IDLE, trig_pc=0, count=0, match_q=0; interrupt=0, int_vec=0, fired_total=0, timeout_flag=0. Reset asserted mid-pending drops interrupt on the next edge.
- All outputs registered; interrupt is combinational OR of registered int_vec.
- match[i] = ((macroscopic_pc & ~3) == trig_pc[i]); match_q[i] registered every cycle; rise[i] = match[i] & ~match_q[i]. Only rising edges trigger, so a PC stalled on the trigger address fires once.
- ack[i] = |m_data_byteen & ((m_data_addr & ~3) == ACK_ADDR) & m_data_wdata[i].
- Per-channel FSM:
  IDLE: cfg_we to this channel with cfg_cnt!=0 -> ARMED (load trig_pc, count). cfg_cnt==0 -> stay IDLE.
  ARMED: rise -> PEND, int_vec[i]=1 on that edge (visible the cycle after the match cycle); fired_total+1 (saturates at 16'hFFFF).
  PEND: ack -> count-1; new count 0 -> DONE, else ARMED; int_vec[i] cleared same edge. A rise while PEND is ignored (no queueing).
  DONE: int_vec=0; only cfg_we re-arms.
- A cfg_we to a channel in any state overrides everything else that edge: it loads the new config, clears int_vec[i], and enters ARMED (or IDLE if cfg_cnt==0). It does not clear timeout_flag. match_q[i] is cleared, so a PC already on the new trigger fires next cycle.
- Ack bits for channels not PEND are ignored. A single store can ack several channels. Stores to other addresses never ack.
- Multiple channels rising in one cycle all go PEND. fired_total then adds the number of channels that rose.
- cfg_ch >= NCH: write ignored.

Optional Feature:
INT_TIMEOUT_EN
- Defined: each channel has a cycle counter, cleared on entry to PEND. If TIMEOUT cycles elapse in PEND without ack, the channel sets timeout_flag[i] (sticky until reset), clears int_vec[i], decrements count and goes to ARMED or DONE exactly as for an ack. Ack in the same cycle as expiry counts as an ack; timeout_flag is not set.
- Undefined: no counters; PEND holds indefinitely; timeout_flag tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with PC=0x3000 and all cfg inputs active -> interrupt=0, int_vec=0, fired_total=0, timeout_flag=0 after release.
- One-shot: cfg ch0 pc=0x3034 cnt=1; drive PC to 0x3034 (and 0x3036) -> int_vec=4'b0001 one cycle later. Store wdata=1, byteen=4'hF to 0x7F20 -> cleared next edge; ch0 DONE; revisiting 0x3034 does not fire; fired_total=1.
- Re-fire and stall: cnt=3, PC held at trigger for 5 cycles -> single assertion. Ack, leave, return, repeated 3 times -> 3 assertions, then DONE; fired_total=3.
- Multi-channel: ch1 and ch2 share pc=0x3100 -> int_vec=4'b0110, fired_total+2. Store wdata=0x2 -> int_vec=4'b0100. Store to 0x7F24 with wdata=0x4 -> unchanged.
- Override: ch3 PEND, cfg_we ch3 cnt=0 in the same cycle as an ack -> int_vec[3]=0, ch3 IDLE, count=0.
- INT_TIMEOUT_EN with TIMEOUT=8, cnt=1, no ack -> int_vec[0] drops exactly 8 cycles after assertion; timeout_flag[0]=1; ch0 DONE. Without the macro -> int_vec[0] stays high for 100 cycles.

Source files
------------

// File: rtl/int_stim_gen.sv
// Multi-channel PC-triggered interrupt stimulus generator: per-channel trigger PC, re-fire count, ack by store.
// Define INT_TIMEOUT_EN to auto-drop a pending channel after TIMEOUT cycles and latch timeout_flag.
module int_stim_gen #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 4,
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int          TIMEOUT  = 256,
  localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_wdata,
  input  logic [3:0]       m_data_byteen,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [31:0]      cfg_pc,
  input  logic [CNT_W-1:0] cfg_cnt,
  output logic             interrupt,
  output logic [NCH-1:0]   int_vec,
  output logic [15:0]      fired_total,
  output logic [NCH-1:0]   timeout_flag
);

  typedef enum logic [1:0] {IDLE, ARMED, PEND, DONE} state_t;

  state_t           state   [NCH];
  logic [31:0]      trig_pc [NCH];
  logic [CNT_W-1:0] count   [NCH];

  logic [NCH-1:0] match;
  logic [NCH-1:0] match_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] ack_bits;
  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] expire;
  logic [31:0]    pc_word;
  logic [31:0]    addr_word;
  logic           store_ack;
  logic [16:0]    fire_sum;

  assign pc_word   = macroscopic_pc & ~32'd3;
  assign addr_word = m_data_addr & ~32'd3;
  assign ack_bits  = NCH'(m_data_wdata);
  assign store_ack = (|m_data_byteen) && (addr_word == ACK_ADDR);
  assign ack       = store_ack ? ack_bits : '0;
  assign interrupt = |int_vec;

  always_comb begin
    match   = '0;
    cfg_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      match[i]   = (pc_word == trig_pc[i]);
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // Edge-only triggering: a PC stalled on the trigger address fires once.
  assign rise = match & ~match_q;

  always_comb begin
    fire = '0;
    for (int i = 0; i < NCH; i++)
      fire[i] = (state[i] == ARMED) && rise[i] && !cfg_hit[i];
  end

  always_comb begin
    fire_sum = {1'b0, fired_total};
    for (int i = 0; i < NCH; i++)
      fire_sum = fire_sum + {16'd0, fire[i]};
  end

`ifdef INT_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] tmr [NCH];

  always_comb begin
    expire = '0;
    for (int i = 0; i < NCH; i++)
      expire[i] = (tmr[i] == TMR_W'(TIMEOUT - 1));
  end
`else
  assign expire       = '0;
  assign timeout_flag = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]   <= IDLE;
        trig_pc[i] <= '0;
        count[i]   <= '0;
`ifdef INT_TIMEOUT_EN
        tmr[i]     <= '0;
`endif
      end
      match_q     <= '0;
      int_vec     <= '0;
      fired_total <= '0;
`ifdef INT_TIMEOUT_EN
      timeout_flag <= '0;
`endif
    end else begin
      fired_total <= fire_sum[16] ? 16'hFFFF : fire_sum[15:0];
      for (int i = 0; i < NCH; i++) begin
        match_q[i] <= cfg_hit[i] ? 1'b0 : match[i];
        // A config write beats any trigger, ack or timeout on the same edge.
        if (cfg_hit[i]) begin
          trig_pc[i] <= cfg_pc & ~32'd3;
          count[i]   <= cfg_cnt;
          int_vec[i] <= 1'b0;
          state[i]   <= (cfg_cnt != '0) ? ARMED : IDLE;
        end else begin
          case (state[i])
            ARMED: begin
              if (rise[i]) begin
                state[i]   <= PEND;
                int_vec[i] <= 1'b1;
`ifdef INT_TIMEOUT_EN
                tmr[i]     <= '0;
`endif
              end
            end
            PEND: begin
              if (ack[i] || expire[i]) begin
                count[i]   <= count[i] - CNT_W'(1);
                state[i]   <= (count[i] == CNT_W'(1)) ? DONE : ARMED;
                int_vec[i] <= 1'b0;
`ifdef INT_TIMEOUT_EN
                if (!ack[i])
                  timeout_flag[i] <= 1'b1;
`endif
              end
`ifdef INT_TIMEOUT_EN
              tmr[i] <= tmr[i] + TMR_W'(1);
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_int_stim_gen.sv
// Directed and randomized bench for int_stim_gen against a counts-and-flags reference model.
module tb_int_stim_gen;
  localparam int          NCH   = 4;
  localparam int          CNT_W = 4;
  localparam logic [31:0] ACK   = 32'h0000_7F20;
  localparam int          TO    = 8;
`ifdef INT_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      macroscopic_pc;
  logic [31:0]      m_data_addr;
  logic [31:0]      m_data_wdata;
  logic [3:0]       m_data_byteen;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [31:0]      cfg_pc;
  logic [CNT_W-1:0] cfg_cnt;
  logic             interrupt;
  logic [NCH-1:0]   int_vec;
  logic [15:0]      fired_total;
  logic [NCH-1:0]   timeout_flag;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  int_stim_gen #(.NCH(NCH), .CNT_W(CNT_W), .ACK_ADDR(ACK), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pc(cfg_pc), .cfg_cnt(cfg_cnt),
    .interrupt(interrupt), .int_vec(int_vec), .fired_total(fired_total),
    .timeout_flag(timeout_flag)
  );

  // Reference model: remaining fires, pending flag, previous-match flag, cycles spent pending.
  int unsigned m_left  [NCH];
  logic [31:0] m_trig  [NCH];
  bit          m_pend  [NCH];
  bit          m_prev  [NCH];
  int          m_age   [NCH];
  bit          m_tflag [NCH];
  int          m_fired;

  task automatic model_edge();
    bit st_ack;
    st_ack = (m_data_byteen != 4'h0) && ((m_data_addr & ~32'h3) == ACK);
    for (int i = 0; i < NCH; i++) begin
      bit on;
      bit rose;
      on   = ((macroscopic_pc & ~32'h3) == m_trig[i]);
      rose = on && !m_prev[i];
      if (!reset) begin
        m_left[i] = 0; m_trig[i] = '0; m_pend[i] = 0; m_prev[i] = 0; m_age[i] = 0; m_tflag[i] = 0;
      end else if (cfg_we && int'(cfg_ch) == i) begin
        m_trig[i] = cfg_pc & ~32'h3;
        m_left[i] = 32'(cfg_cnt);
        m_pend[i] = 0;
        m_prev[i] = 0;
      end else begin
        m_prev[i] = on;
        if (m_pend[i]) begin
          m_age[i]++;
          if (st_ack && m_data_wdata[i]) begin
            m_pend[i] = 0; m_left[i]--;
          end else if (TO_ON && m_age[i] >= TO) begin
            m_pend[i] = 0; m_left[i]--; m_tflag[i] = 1;
          end
        end else if (m_left[i] > 0 && rose) begin
          m_pend[i] = 1;
          m_age[i]  = 0;
          if (m_fired < 65535) m_fired++;
        end
      end
    end
    if (!reset) m_fired = 0;
  endtask

  function automatic logic [NCH-1:0] mvec();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_pend[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] mtf();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_tflag[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_idle();
    cfg_we = 0; cfg_ch = '0; cfg_pc = '0; cfg_cnt = '0;
    m_data_addr = '0; m_data_wdata = '0; m_data_byteen = '0;
  endtask

  task automatic apply_reset();
    bus_idle();
    macroscopic_pc = '0;
    reset = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic cfg(input int ch, input logic [31:0] pc, input int cnt);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_pc = pc; cfg_cnt = 4'(cnt);
    tick();
    cfg_we = 0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    m_data_addr = addr; m_data_wdata = data; m_data_byteen = be;
    tick();
    m_data_byteen = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    macroscopic_pc = 32'h3000;
    cfg_we = 1; cfg_ch = 2'd0; cfg_pc = 32'h3000; cfg_cnt = 4'd5;
    m_data_addr = ACK; m_data_wdata = 32'hF; m_data_byteen = 4'hF;
    repeat (3) tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL reset_vec got=%b exp=0000", int_vec); else passed++;
    reset = 1;
    bus_idle();
    tick();
    checks++; if (interrupt !== 1'b0) $display("FAIL reset_int got=%b exp=0", interrupt); else passed++;
    checks++; if (int_vec !== 4'b0000) $display("FAIL reset_vec_rel got=%b exp=0000", int_vec); else passed++;
    checks++; if (fired_total !== 16'd0) $display("FAIL reset_fired got=%0d exp=0", fired_total); else passed++;
    checks++; if (timeout_flag !== 4'b0000) $display("FAIL reset_tflag got=%b exp=0000", timeout_flag); else passed++;
    tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL reset_no_arm got=%b exp=0000", int_vec); else passed++;
  endtask

  task automatic test_one_shot();
    apply_reset();
    cfg(0, 32'h3034, 1);
    macroscopic_pc = 32'h3034;
    checks++; if (int_vec !== 4'b0000) $display("FAIL oneshot_pre got=%b exp=0000", int_vec); else passed++;
    tick();
    checks++; if (int_vec !== 4'b0001) $display("FAIL oneshot_fire got=%b exp=0001", int_vec); else passed++;
    macroscopic_pc = 32'h3036;
    tick();
    checks++; if (interrupt !== 1'b1) $display("FAIL oneshot_hold got=%b exp=1", interrupt); else passed++;
    store(ACK, 32'h1, 4'hF);
    checks++; if (int_vec !== 4'b0000) $display("FAIL oneshot_ack got=%b exp=0000", int_vec); else passed++;
    macroscopic_pc = 32'h1000; tick();
    macroscopic_pc = 32'h3034; tick(); tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL oneshot_done got=%b exp=0000", int_vec); else passed++;
    checks++; if (fired_total !== 16'd1) $display("FAIL oneshot_fired got=%0d exp=1", fired_total); else passed++;
  endtask

  task automatic test_refire();
    apply_reset();
    cfg(0, 32'h3200, 3);
    macroscopic_pc = 32'h3200;
    repeat (5) tick();
    checks++; if (fired_total !== 16'd1) $display("FAIL refire_stall got=%0d exp=1", fired_total); else passed++;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        macroscopic_pc = 32'h1000; tick();
        macroscopic_pc = 32'h3200; tick();
      end
      checks++; if (int_vec[0] !== 1'b1) $display("FAIL refire_fire%0d got=%b exp=1", k, int_vec[0]); else passed++;
      store(ACK, 32'h1, 4'h1);
      checks++; if (int_vec[0] !== 1'b0) $display("FAIL refire_ack%0d got=%b exp=0", k, int_vec[0]); else passed++;
    end
    macroscopic_pc = 32'h1000; tick();
    macroscopic_pc = 32'h3200; tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL refire_done got=%b exp=0000", int_vec); else passed++;
    checks++; if (fired_total !== 16'd3) $display("FAIL refire_fired got=%0d exp=3", fired_total); else passed++;
  endtask

  task automatic test_multi();
    apply_reset();
    cfg(1, 32'h3100, 1);
    cfg(2, 32'h3100, 1);
    macroscopic_pc = 32'h3100;
    tick();
    checks++; if (int_vec !== 4'b0110) $display("FAIL multi_fire got=%b exp=0110", int_vec); else passed++;
    checks++; if (fired_total !== 16'd2) $display("FAIL multi_fired got=%0d exp=2", fired_total); else passed++;
    store(ACK, 32'h2, 4'hF);
    checks++; if (int_vec !== 4'b0100) $display("FAIL multi_ack1 got=%b exp=0100", int_vec); else passed++;
    store(32'h7F24, 32'h4, 4'hF);
    checks++; if (int_vec !== 4'b0100) $display("FAIL multi_other_addr got=%b exp=0100", int_vec); else passed++;
    store(ACK, 32'h4, 4'h0);
    checks++; if (int_vec !== 4'b0100) $display("FAIL multi_no_byteen got=%b exp=0100", int_vec); else passed++;
    store(32'h7F23, 32'hF, 4'h8);
    checks++; if (int_vec !== 4'b0000) $display("FAIL multi_low_bits got=%b exp=0000", int_vec); else passed++;
  endtask

  task automatic test_override();
    apply_reset();
    cfg(3, 32'h3300, 2);
    macroscopic_pc = 32'h3300;
    tick();
    checks++; if (int_vec !== 4'b1000) $display("FAIL ovr_fire got=%b exp=1000", int_vec); else passed++;
    cfg_we = 1; cfg_ch = 2'd3; cfg_pc = 32'h3300; cfg_cnt = 4'd0;
    m_data_addr = ACK; m_data_wdata = 32'h8; m_data_byteen = 4'hF;
    tick();
    bus_idle();
    checks++; if (int_vec !== 4'b0000) $display("FAIL ovr_clear got=%b exp=0000", int_vec); else passed++;
    macroscopic_pc = 32'h1000; tick();
    macroscopic_pc = 32'h3300; tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL ovr_idle got=%b exp=0000", int_vec); else passed++;
    cfg(3, 32'h3300, 1);
    checks++; if (int_vec !== 4'b0000) $display("FAIL ovr_rearm got=%b exp=0000", int_vec); else passed++;
    tick();
    checks++; if (int_vec !== 4'b1000) $display("FAIL ovr_onpc got=%b exp=1000", int_vec); else passed++;
    checks++; if (fired_total !== 16'd2) $display("FAIL ovr_fired got=%0d exp=2", fired_total); else passed++;
  endtask

  task automatic test_timeout();
    int high;
    apply_reset();
    cfg(0, 32'h3400, 1);
    macroscopic_pc = 32'h3400;
    tick();
`ifdef INT_TIMEOUT_EN
    high = 0;
    for (int k = 0; k < 20; k++) begin
      if (int_vec[0]) high++;
      tick();
    end
    checks++; if (high !== 8) $display("FAIL tmo_width got=%0d exp=8", high); else passed++;
    checks++; if (timeout_flag !== 4'b0001) $display("FAIL tmo_flag got=%b exp=0001", timeout_flag); else passed++;
    macroscopic_pc = 32'h1000; tick();
    macroscopic_pc = 32'h3400; tick();
    checks++; if (int_vec !== 4'b0000) $display("FAIL tmo_done got=%b exp=0000", int_vec); else passed++;
    cfg(1, 32'h3500, 2);
    macroscopic_pc = 32'h3500;
    tick();
    repeat (7) tick();
    checks++; if (int_vec !== 4'b0010) $display("FAIL tmo_prelim got=%b exp=0010", int_vec); else passed++;
    store(ACK, 32'h2, 4'hF);
    checks++; if (int_vec !== 4'b0000) $display("FAIL tmo_ack_tie got=%b exp=0000", int_vec); else passed++;
    checks++; if (timeout_flag !== 4'b0001) $display("FAIL tmo_ack_flag got=%b exp=0001", timeout_flag); else passed++;
    cfg(0, 32'h3600, 1);
    checks++; if (timeout_flag !== 4'b0001) $display("FAIL tmo_sticky got=%b exp=0001", timeout_flag); else passed++;
`else
    high = 0;
    for (int k = 0; k < 100; k++) begin
      if (int_vec[0]) high++;
      tick();
    end
    checks++; if (high !== 100) $display("FAIL hold_width got=%0d exp=100", high); else passed++;
    checks++; if (int_vec !== 4'b0001) $display("FAIL hold_vec got=%b exp=0001", int_vec); else passed++;
    checks++; if (timeout_flag !== 4'b0000) $display("FAIL hold_tflag got=%b exp=0000", timeout_flag); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cfg(0, 32'h3000, 1);
    macroscopic_pc = 32'h3000;
    tick();
    checks++; if (interrupt !== 1'b1) $display("FAIL midrst_pre got=%b exp=1", interrupt); else passed++;
    reset = 0;
    tick();
    checks++; if (interrupt !== 1'b0) $display("FAIL midrst_int got=%b exp=0", interrupt); else passed++;
    checks++; if (fired_total !== 16'd0) $display("FAIL midrst_fired got=%0d exp=0", fired_total); else passed++;
    reset = 1;
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    logic [31:0] addrs [5];
    logic [NCH-1:0] ev;
    logic [NCH-1:0] et;
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008; pcs[3] = 32'h300C;
    addrs[0] = ACK; addrs[1] = 32'h7F21; addrs[2] = 32'h7F23; addrs[3] = 32'h7F24; addrs[4] = 32'h7F1C;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 1) == 0)
        macroscopic_pc = pcs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_pc = pcs[$urandom_range(0, 3)];
      cfg_cnt = 4'($urandom_range(0, 3));
      m_data_byteen = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      m_data_addr = addrs[$urandom_range(0, 4)];
      m_data_wdata = $urandom;
      tick();
      ev = mvec();
      et = mtf();
      checks++;
      if ({interrupt, int_vec, fired_total, timeout_flag} !== {|ev, ev, 16'(m_fired), et})
        $display("FAIL random cyc=%0d int=%b vec=%b fired=%0d tflag=%b exp vec=%b fired=%0d tflag=%b",
                 c, interrupt, int_vec, fired_total, timeout_flag, ev, m_fired, et);
      else passed++;
    end
    bus_idle();
  endtask

  initial begin
    reset = 0;
    macroscopic_pc = '0;
    bus_idle();
    for (int i = 0; i < NCH; i++) begin
      m_left[i] = 0; m_trig[i] = '0; m_pend[i] = 0; m_prev[i] = 0; m_age[i] = 0; m_tflag[i] = 0;
    end
    m_fired = 0;
    test_reset();
    test_one_shot();
    test_refire();
    test_multi();
    test_override();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
